// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into instruction memory word writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int IW = $clog2(MEM_SIZE) + 1;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t        state;
    state_t        state_n;
    logic [15:0]   len;
    logic [15:0]   len_full;
    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic [23:0]   word;
    logic          xfer;
    logic          last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign len_full  = {byte_data, len[7:0]};
    assign last_word = (16'(idx) == len - 16'd1);

    always_comb begin
        state_n = state;
        unique case (state)
            LEN_LO: if (xfer) state_n = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_full > 16'(MEM_SIZE))
                        state_n = ERROR;
                    else if (len_full == 16'd0)
                        state_n = FIN;
                    else
                        state_n = DATA;
                end
            end
            DATA: if (xfer && lane == 2'd3 && last_word) state_n = FIN;
`ifdef LOADER_CHECKSUM_EN
            CHK: if (xfer) state_n = (byte_data == csum) ? DONE : ERROR;
`endif
            DONE:  if (start) state_n = LEN_LO;
            ERROR: if (start) state_n = LEN_LO;
            default: state_n = LEN_LO;
        endcase
    end

    // Status outputs are registered from the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LEN_LO;
            len        <= '0;
            idx        <= '0;
            lane       <= '0;
            word       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            imem_we    <= 1'b0;
            byte_ready <= (state_n != DONE) && (state_n != ERROR);
            cpu_hold   <= (state_n != DONE);
            done       <= (state_n == DONE);
            error      <= (state_n == ERROR);
            if (xfer) begin
                unique case (state)
                    LEN_LO: begin
                        len[7:0] <= byte_data;
                        idx      <= '0;
                        lane     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                    LEN_HI: len[15:8] <= byte_data;
                    DATA: begin
                        lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        unique case (lane)
                            2'd0: word[7:0]   <= byte_data;
                            2'd1: word[15:8]  <= byte_data;
                            2'd2: word[23:16] <= byte_data;
                            2'd3: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= {{(30-IW){1'b0}}, idx, 2'b00};
                                imem_wdata <= {byte_data, word};
                                idx        <= idx + IW'(1);
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
